// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: FSM encoding,
// control-bit positions, byte-enable constants and lane helpers.
package mem_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit positions of the memory/writeback control bits in the ex_mem control word
  localparam int MEMTOREG = 3;
  localparam int MEMREAD  = 4;
  localparam int MEMWRITE = 5;
  localparam int REGWRITE = 6;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic       is_load;
    logic       is_byte;
    logic       is_unsigned;
    logic [1:0] lane;
  } req_ctrl_t;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  function automatic logic [31:0] replicate_byte(input logic [7:0] b);
    return {4{b}};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/ready data-memory bus between the load/store unit (master)
// and the data memory (slave).
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memWdata;
  logic [3:0]        memBe;
  logic              memReady;
  logic [31:0]       memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata, memBe,
    input  memReady, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata, memBe,
    output memReady, memRdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load formatter: selects a byte lane and sign/zero-extends it,
// or passes the whole word through for word loads.
module load_extend (
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic        is_byte,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0] lane_byte;

  always_comb begin
    case (lane)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase

    if (!is_byte) begin
      result = rdata;
    end else if (is_unsigned) begin
      result = {24'd0, lane_byte};
    end else begin
      result = {{24{lane_byte[7]}}, lane_byte};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives the data-memory handshake, freezes the
// pipeline while an access is outstanding and formats load results for mem_wb.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   inResult,
  input  logic [31:0]         inWriteData,
  input  logic                inMemRead,
  input  logic                inMemWrite,
  input  logic                inByte,
  input  logic                inUnsigned,
  mem_access_unit_if.master   mem,
  output logic [31:0]         outReadData,
  output logic                outStall,
  output logic                outMisaligned,
  output logic                outBusError
);

  logic [1:0]        state;
  logic [TO_W-1:0]   count;
  req_ctrl_t         ctrl;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;
  logic [31:0]       read_data_q;
  logic              bus_err_q;
  logic [31:0]       ext_data;

  logic request;
  logic misaligned;
  logic start_access;

  assign request      = inMemRead | inMemWrite;
  assign misaligned   = ~inByte & (inResult[1:0] != 2'b00);
  assign start_access = (state == ST_IDLE) & request & ~misaligned;

  assign outStall      = start_access | (state == ST_BUSY);
  assign outMisaligned = (state == ST_IDLE) & request & misaligned;
  assign outBusError   = bus_err_q;
  assign outReadData   = read_data_q;

  assign mem.memReq   = req_q;
  assign mem.memWe    = we_q;
  assign mem.memAddr  = addr_q;
  assign mem.memWdata = wdata_q;
  assign mem.memBe    = be_q;

  // Lane/extension controls are captured at request time so the result does
  // not depend on the frozen ex_mem register staying perfectly stable.
  load_extend u_load_extend (
    .rdata       (mem.memRdata),
    .lane        (ctrl.lane),
    .is_byte     (ctrl.is_byte),
    .is_unsigned (ctrl.is_unsigned),
    .result      (ext_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      ctrl        <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= BE_NONE;
      read_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus_err_q <= 1'b0;
          if (request && misaligned) begin
            read_data_q <= '0;
          end else if (request) begin
            addr_q           <= {inResult[ADDR_W-1:2], 2'b00};
            wdata_q          <= inByte ? replicate_byte(inWriteData[7:0]) : inWriteData;
            be_q             <= inByte ? lane_be(inResult[1:0]) : BE_WORD;
            we_q             <= inMemWrite;
            req_q            <= 1'b1;
            count            <= '0;
            ctrl.is_load     <= inMemRead & ~inMemWrite;
            ctrl.is_byte     <= inByte;
            ctrl.is_unsigned <= inUnsigned;
            ctrl.lane        <= inResult[1:0];
            state            <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (mem.memReady) begin
            if (ctrl.is_load) begin
              read_data_q <= ext_data;
            end
            req_q <= 1'b0;
            we_q  <= 1'b0;
            state <= ST_DONE;
          end else if (count == TO_W'(TIMEOUT - 1)) begin
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            read_data_q <= '0;
            bus_err_q   <= 1'b1;
            state       <= ST_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end

        // One unstalled cycle lets the frozen instruction advance into mem_wb.
        ST_DONE: begin
          bus_err_q <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
